// File: rtl/uart_frame_rx.sv
// UART 8N1 receiver and frame parser: hunts for a sync byte, streams PIXELS bytes to an
// image buffer write port and validates a trailing XOR checksum.
module uart_frame_rx #(
  parameter int          CLK_HZ    = 100_000_000,
  parameter int          BAUD      = 115_200,
  parameter int          PIXELS    = 784,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 2_000_000,
  localparam int         AW        = $clog2(PIXELS)
) (
  input  logic          sys_clk,
  input  logic          reset_rtl_0,
  input  logic          uart_rxd,
  output logic          pix_we,
  output logic [AW-1:0] pix_addr,
  output logic [7:0]    pix_data,
  output logic          frame_done,
  output logic          frame_err,
  output logic          busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int TW           = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_PIX,
    F_CHK
  } frame_state_t;

  logic            rxd_meta;
  logic            rxd_sync;
  logic            rxd_prev;
  rx_state_t       rx_state;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;

  // byte_valid / stop_err: one-cycle pulses from the bit engine with no ready;
  // the frame FSM consumes every pulse in the cycle it appears.
  logic            byte_valid;
  logic [7:0]      rx_byte;
  logic            stop_err;

  frame_state_t    frame_state;
  logic [AW-1:0]   pix_cnt;
  logic [7:0]      xor_acc;
  logic [TW-1:0]   idle_cnt;

  always_ff @(posedge sys_clk) begin
    if (reset_rtl_0) begin
      rxd_meta   <= 1'b1;
      rxd_sync   <= 1'b1;
      rxd_prev   <= 1'b1;
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      stop_err   <= 1'b0;
    end else begin
      rxd_meta   <= uart_rxd;
      rxd_sync   <= rxd_meta;
      rxd_prev   <= rxd_sync;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rxd_prev && !rxd_sync) begin
            clk_cnt  <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Mid-start-bit check rejects short glitches on the idle line.
          if (clk_cnt == CW'(HALF_BIT - 1)) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt   <= '0;
            shift_reg <= {rxd_sync, shift_reg[7:1]};
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              rx_state <= RX_STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            if (rxd_sync) begin
              byte_valid <= 1'b1;
              rx_byte    <= shift_reg;
              rx_state   <= RX_IDLE;
            end else begin
              stop_err <= 1'b1;
              rx_state <= RX_WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rxd_sync) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // idle_cnt counts cycles since the last byte_valid, starting at 1 on the cycle
  // after it, so frame_err lands exactly TIMEOUT cycles after that byte_valid.
  always_ff @(posedge sys_clk) begin
    if (reset_rtl_0) begin
      frame_state <= F_IDLE;
      pix_cnt     <= '0;
      xor_acc     <= '0;
      idle_cnt    <= '0;
      pix_we      <= 1'b0;
      pix_addr    <= '0;
      pix_data    <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pix_we     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (frame_state)
        F_IDLE: begin
          if (byte_valid && rx_byte == SYNC_BYTE) begin
            frame_state <= F_PIX;
            busy        <= 1'b1;
            pix_cnt     <= '0;
            xor_acc     <= '0;
            idle_cnt    <= TW'(1);
          end
        end
        F_PIX: begin
          if (byte_valid) begin
            pix_we   <= 1'b1;
            pix_addr <= pix_cnt;
            pix_data <= rx_byte;
            xor_acc  <= xor_acc ^ rx_byte;
            idle_cnt <= TW'(1);
            if (pix_cnt == AW'(PIXELS - 1)) begin
              frame_state <= F_CHK;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end else if (stop_err || idle_cnt == TW'(TIMEOUT - 1)) begin
            frame_err   <= 1'b1;
            busy        <= 1'b0;
            frame_state <= F_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        F_CHK: begin
          if (byte_valid) begin
            if (rx_byte == xor_acc) begin
              frame_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            busy        <= 1'b0;
            frame_state <= F_IDLE;
          end else if (stop_err || idle_cnt == TW'(TIMEOUT - 1)) begin
            frame_err   <= 1'b1;
            busy        <= 1'b0;
            frame_state <= F_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: frame_state <= F_IDLE;
      endcase
    end
  end

endmodule
